// File: rtl/en_extmem_ctrl_pkg.sv
// Shared token types, widths and controller state encoding for the ElectronNest
// external-memory path.
package pkg_en;

  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 8;

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic c;
  } BTk_t;

  typedef enum logic [1:0] {
    EXM_IDLE,
    EXM_PRE,
    EXM_IMG,
    EXM_RUN
  } exm_state_t;

  function automatic logic exm_booting(input exm_state_t s);
    return (s == EXM_PRE) || (s == EXM_IMG);
  endfunction

endpackage

// File: rtl/en_extmem_ctrl_boot_seq.sv
// Boot sequencer: walks the preamble and image, issues image reads one cycle
// ahead and registers one boot token per cycle.
module en_extmem_boot_seq
  import pkg_en::*;
#(
  parameter int BOOT_PRE = 3,
  parameter int BOOT_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH_DATA-1:0]   mem_rdata,
  output exm_state_t              state,
  output logic                    busy,
  output logic                    rd_en,
  output logic [WIDTH_EXADDR-1:0] rd_addr,
  output FTk_t                    tok
);

  localparam int BOOT_TOT = BOOT_PRE + BOOT_LEN;
  localparam int CNT_W    = $clog2(BOOT_TOT + 1);

  exm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  FTk_t             tok_q, tok_d;
  int               cnt_i, nxt_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tok_d   = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    cnt_i   = int'(cnt_q);
    nxt_i   = cnt_i + 1;
    unique case (state_q)
      EXM_IDLE: begin
        if (start) begin
          state_d = (BOOT_PRE > 0) ? EXM_PRE : EXM_IMG;
          cnt_d   = '0;
          // With no preamble the first image read must already go out here.
          if (BOOT_PRE == 0 && BOOT_LEN > 0) rd_en = 1'b1;
        end
      end
      EXM_PRE, EXM_IMG: begin
        tok_d.v = 1'b1;
        tok_d.a = (cnt_i == 0);
        if (cnt_i >= BOOT_PRE) tok_d.d = mem_rdata;
        // Read for the next count's word, so its data lands while that count is processed.
        if (nxt_i >= BOOT_PRE && nxt_i < BOOT_TOT) begin
          rd_en   = 1'b1;
          rd_addr = WIDTH_EXADDR'(nxt_i - BOOT_PRE);
        end
        if (nxt_i >= BOOT_TOT) begin
          state_d = EXM_RUN;
        end else begin
          cnt_d   = CNT_W'(nxt_i);
          state_d = (nxt_i >= BOOT_PRE) ? EXM_IMG : EXM_PRE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EXM_IDLE;
      cnt_q   <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
    end
  end

  assign state = state_q;
  assign busy  = exm_booting(state_q);
  assign tok   = tok_q;

endmodule

// File: rtl/en_extmem_ctrl.sv
// External memory controller: boot streaming, then load-priority arbitration of
// EN load/store ports onto one single-port synchronous memory.
module en_extmem_ctrl
  import pkg_en::*;
#(
  parameter int BOOT_PRE   = 3,
  parameter int BOOT_LEN   = 5,
  parameter int STARVE_LIM = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  output logic                    O_Mem_En,
  output logic                    O_Mem_We,
  output logic [WIDTH_EXADDR-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]   O_Mem_WData,
  input  logic [WIDTH_DATA-1:0]   I_Mem_RData,
  output logic                    O_Busy,
  output logic                    O_St_Starve,
  output logic                    O_Err
);

  localparam int STV_W = $clog2(STARVE_LIM + 1);

  exm_state_t              state;
  logic                    boot_busy;
  logic                    boot_rd_en;
  logic [WIDTH_EXADDR-1:0] boot_rd_addr;
  FTk_t                    boot_tok;

  logic                    run, st_pend, ld_go, st_go, st_nack;
  logic [STV_W-1:0]        starve_q, starve_d;
  logic                    err_q, err_d;
  logic                    ld_vld_q, ld_vld_d;
  logic [WIDTH_EXADDR-1:0] ld_addr_q, ld_addr_d;
  logic                    tok_fields_unused;

  en_extmem_boot_seq #(
    .BOOT_PRE(BOOT_PRE),
    .BOOT_LEN(BOOT_LEN)
  ) u_boot (
    .clk      (clock),
    .rst_n    (reset),
    .start    (I_Boot),
    .mem_rdata(I_Mem_RData),
    .state    (state),
    .busy     (boot_busy),
    .rd_en    (boot_rd_en),
    .rd_addr  (boot_rd_addr),
    .tok      (boot_tok)
  );

  assign tok_fields_unused = ^{I_Ld_BTk, I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i};

  assign run     = (state == EXM_RUN);
  assign st_pend = I_St_Req & I_St_FTk.v;
  assign ld_go   = run & I_Ld_Req;
  assign st_go   = run & st_pend & ~I_Ld_Req;
  assign st_nack = st_pend & (boot_busy | ld_go);

  always_comb begin
    O_Mem_En    = 1'b0;
    O_Mem_We    = 1'b0;
    O_Mem_Addr  = '0;
    O_Mem_WData = '0;
    if (boot_busy) begin
      O_Mem_En   = boot_rd_en;
      O_Mem_Addr = boot_rd_addr;
    end else if (ld_go) begin
      O_Mem_En   = 1'b1;
      O_Mem_Addr = I_Ld_Addr;
    end else if (st_go) begin
      O_Mem_En    = 1'b1;
      O_Mem_We    = 1'b1;
      O_Mem_Addr  = I_St_Addr;
      O_Mem_WData = I_St_FTk.d;
    end
  end

  always_comb begin
    O_St_BTk   = '0;
    O_St_BTk.n = st_nack;
  end

  // Boot tokens are fully registered; load data passes straight from the memory port.
  always_comb begin
    O_Ld_FTk = '0;
    if (boot_tok.v) begin
      O_Ld_FTk = boot_tok;
    end else if (ld_vld_q) begin
      O_Ld_FTk.v = 1'b1;
      O_Ld_FTk.i = ld_addr_q;
      O_Ld_FTk.d = I_Mem_RData;
    end
  end

  always_comb begin
    starve_d  = '0;
    if (st_nack) begin
      starve_d = (starve_q == STV_W'(STARVE_LIM)) ? starve_q : starve_q + STV_W'(1);
    end
    err_d     = err_q | (boot_busy & I_Ld_Req) | (run & I_St_FTk.v & ~I_St_Req);
    ld_vld_d  = ld_go;
    ld_addr_d = ld_go ? I_Ld_Addr : ld_addr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q  <= '0;
      err_q     <= 1'b0;
      ld_vld_q  <= 1'b0;
      ld_addr_q <= '0;
    end else begin
      starve_q  <= starve_d;
      err_q     <= err_d;
      ld_vld_q  <= ld_vld_d;
      ld_addr_q <= ld_addr_d;
    end
  end

  assign O_Busy      = boot_busy;
  assign O_St_Starve = (starve_q == STV_W'(STARVE_LIM));
  assign O_Err       = err_q;

endmodule

// File: tb/tb_en_extmem_ctrl.sv
// Scoreboard bench for en_extmem_ctrl: boot stream, load/store arbitration,
// starvation flag, error flag and asynchronous reset mid-boot.
module tb_en_extmem_ctrl;
  import pkg_en::*;

  localparam int DEPTH = 1 << WIDTH_EXADDR;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    I_Boot;
  logic                    I_Ld_Req;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr;
  FTk_t                    O_Ld_FTk;
  BTk_t                    I_Ld_BTk;
  logic                    I_St_Req;
  logic [WIDTH_EXADDR-1:0] I_St_Addr;
  FTk_t                    I_St_FTk;
  BTk_t                    O_St_BTk;
  logic                    O_Mem_En;
  logic                    O_Mem_We;
  logic [WIDTH_EXADDR-1:0] O_Mem_Addr;
  logic [WIDTH_DATA-1:0]   O_Mem_WData;
  logic [WIDTH_DATA-1:0]   I_Mem_RData;
  logic                    O_Busy;
  logic                    O_St_Starve;
  logic                    O_Err;

  logic [WIDTH_DATA-1:0] mem [0:DEPTH-1];
  FTk_t sb [$];
  FTk_t mon_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  en_extmem_ctrl #(
    .BOOT_PRE  (3),
    .BOOT_LEN  (5),
    .STARVE_LIM(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Boot     (I_Boot),
    .I_Ld_Req   (I_Ld_Req),
    .I_Ld_Addr  (I_Ld_Addr),
    .O_Ld_FTk   (O_Ld_FTk),
    .I_Ld_BTk   (I_Ld_BTk),
    .I_St_Req   (I_St_Req),
    .I_St_Addr  (I_St_Addr),
    .I_St_FTk   (I_St_FTk),
    .O_St_BTk   (O_St_BTk),
    .O_Mem_En   (O_Mem_En),
    .O_Mem_We   (O_Mem_We),
    .O_Mem_Addr (O_Mem_Addr),
    .O_Mem_WData(O_Mem_WData),
    .I_Mem_RData(I_Mem_RData),
    .O_Busy     (O_Busy),
    .O_St_Starve(O_St_Starve),
    .O_Err      (O_Err)
  );

  // Synchronous single-port BRAM, reloaded with the boot image while reset is low.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int j = 0; j < 5; j++) mem[j] <= 32'hA0 + 32'(j);
      mem[7]      <= 32'h55;
      I_Mem_RData <= '0;
    end else if (O_Mem_En) begin
      if (O_Mem_We) mem[O_Mem_Addr] <= O_Mem_WData;
      else          I_Mem_RData     <= mem[O_Mem_Addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic FTk_t mk_tok(input logic a, input logic [WIDTH_EXADDR-1:0] i,
                                  input logic [WIDTH_DATA-1:0] d);
    FTk_t t;
    t   = '0;
    t.v = 1'b1;
    t.a = a;
    t.i = i;
    t.d = d;
    return t;
  endfunction

  always @(negedge clock) begin
    if (reset && O_Ld_FTk.v) begin
      if (sb.size() == 0) begin
        check_eq("ld_unexpected", 64'(O_Ld_FTk), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("ld_tok", 64'(O_Ld_FTk), 64'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    I_Boot    = 1'b0;
    I_Ld_Req  = 1'b0;
    I_Ld_Addr = '0;
    I_St_Req  = 1'b0;
    I_St_Addr = '0;
    I_St_FTk  = '0;
  endtask

  task automatic drive_load(input logic [WIDTH_EXADDR-1:0] a, input logic [WIDTH_DATA-1:0] exp);
    I_Ld_Req  = 1'b1;
    I_Ld_Addr = a;
    sb.push_back(mk_tok(1'b0, a, exp));
  endtask

  task automatic drive_store(input logic [WIDTH_EXADDR-1:0] a, input logic [WIDTH_DATA-1:0] d);
    I_St_Req  = 1'b1;
    I_St_Addr = a;
    I_St_FTk  = mk_tok(1'b0, '0, d);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ldftk"}, 64'(O_Ld_FTk), 64'd0);
    check_eq({tag, "_stbtk"}, 64'(O_St_BTk), 64'd0);
    check_eq({tag, "_memen"}, 64'(O_Mem_En), 64'd0);
    check_eq({tag, "_busy"},  64'(O_Busy), 64'd0);
    check_eq({tag, "_err"},   64'(O_Err), 64'd0);
    check_eq({tag, "_starve"}, 64'(O_St_Starve), 64'd0);
  endtask

  // Boot from IDLE; abort_at >= 0 asserts reset in that token cycle (index from first token).
  task automatic run_boot(input bit ld_in_boot, input int abort_at);
    for (int k = 0; k < 8; k++)
      sb.push_back(mk_tok(k == 0, '0, (k < 3) ? 32'h0 : 32'(32'hA0 + k - 3)));
    I_Boot = 1'b1;
    step();
    I_Boot = 1'b0;
    drive_store(8'd30, 32'hDEAD);
    @(negedge clock);
    check_eq("boot_busy0", 64'(O_Busy), 64'd1);
    check_eq("boot_st_nack", 64'(O_St_BTk.n), 64'd1);
    check_eq("boot_st_nowe", 64'(O_Mem_We), 64'd0);
    check_eq("boot_notok0", 64'(O_Ld_FTk.v), 64'd0);
    step();
    idle_in();
    for (int c = 0; c < 8; c++) begin
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        return;
      end
      I_Ld_Req = ld_in_boot && (c == 1);
      @(negedge clock);
      check_eq("boot_v", 64'(O_Ld_FTk.v), 64'd1);
      check_eq("boot_busy", 64'(O_Busy), 64'(c < 7));
      step();
    end
    I_Ld_Req = 1'b0;
    @(negedge clock);
    check_eq("run_notok", 64'(O_Ld_FTk.v), 64'd0);
    check_eq("run_busy", 64'(O_Busy), 64'd0);
    check_eq("boot_sb_empty", 64'(sb.size()), 64'd0);
    step();
  endtask

  initial begin
    idle_in();
    I_Ld_BTk = '0;
    reset    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("rst");
    step();
    reset = 1'b1;

    run_boot(1'b0, -1);

    // Boot pulse in RUN is ignored
    I_Boot = 1'b1;
    step();
    I_Boot = 1'b0;
    @(negedge clock);
    check_eq("reboot_ignored", 64'(O_Busy), 64'd0);
    step();

    drive_load(8'd7, 32'h55);
    @(negedge clock);
    check_eq("ld_en", 64'(O_Mem_En), 64'd1);
    check_eq("ld_we", 64'(O_Mem_We), 64'd0);
    check_eq("ld_addr", 64'(O_Mem_Addr), 64'd7);
    step();
    idle_in();
    step();
    @(negedge clock);
    check_eq("ld_idle_v", 64'(O_Ld_FTk.v), 64'd0);
    step();

    drive_store(8'd9, 32'h1234);
    @(negedge clock);
    check_eq("st_we", 64'(O_Mem_We), 64'd1);
    check_eq("st_addr", 64'(O_Mem_Addr), 64'd9);
    check_eq("st_wdata", 64'(O_Mem_WData), 64'h1234);
    check_eq("st_n", 64'(O_St_BTk.n), 64'd0);
    step();
    idle_in();
    drive_load(8'd9, 32'h1234);
    step();
    idle_in();
    step();

    // Load and store to the same address: load reads old data, store retries
    for (int i = 0; i < 3; i++) begin
      drive_load(8'd7, 32'h55);
      drive_store(8'd7, 32'hBEEF);
      @(negedge clock);
      check_eq("col_nack", 64'(O_St_BTk.n), 64'd1);
      check_eq("col_nowe", 64'(O_Mem_We), 64'd0);
      step();
    end
    I_Ld_Req = 1'b0;
    @(negedge clock);
    check_eq("col_grant_n", 64'(O_St_BTk.n), 64'd0);
    check_eq("col_grant_we", 64'(O_Mem_We), 64'd1);
    check_eq("col_grant_wd", 64'(O_Mem_WData), 64'hBEEF);
    step();
    idle_in();
    drive_load(8'd7, 32'hBEEF);
    step();
    idle_in();
    step();

    drive_store(8'd20, 32'h77);
    for (int i = 0; i < 16; i++) begin
      drive_load(8'd0, 32'hA0);
      @(negedge clock);
      check_eq("starve_low", 64'(O_St_Starve), 64'd0);
      step();
    end
    I_Ld_Req = 1'b0;
    @(negedge clock);
    check_eq("starve_high", 64'(O_St_Starve), 64'd1);
    check_eq("starve_grant_we", 64'(O_Mem_We), 64'd1);
    step();
    idle_in();
    @(negedge clock);
    check_eq("starve_clear", 64'(O_St_Starve), 64'd0);
    step();

    I_St_FTk = mk_tok(1'b0, '0, 32'h99);
    @(negedge clock);
    check_eq("err_pre", 64'(O_Err), 64'd0);
    check_eq("err_nowe", 64'(O_Mem_We), 64'd0);
    step();
    idle_in();
    @(negedge clock);
    check_eq("err_stv", 64'(O_Err), 64'd1);
    step();

    reset = 1'b0;
    #1;
    check_eq("err_rst", 64'(O_Err), 64'd0);
    step();
    reset = 1'b1;
    run_boot(1'b0, 4);
    step();
    reset = 1'b1;
    run_boot(1'b1, -1);
    check_eq("err_ld_boot", 64'(O_Err), 64'd1);
    repeat (3) step();
    check_eq("err_sticky", 64'(O_Err), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("err_final_rst", 64'(O_Err), 64'd0);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
